// File: rtl/bf_pkg.sv
// Shared constants and the default data word for the bf_* pipeline buffer family.
// Latency: none (declarations only); backpressure: not applicable.
package bf_pkg;

  localparam int BF_DEFAULT_WIDTH = 32;

  typedef logic [BF_DEFAULT_WIDTH-1:0] bf_word_t;

endpackage : bf_pkg

// File: rtl/bf_stage.sv
// Single WIDTH-bit pipeline flop with sync reset, sync flush and load enable.
// Latency: 1 enabled cycle; backpressure: EN low holds the stored word.
module bf_stage
  import bf_pkg::*;
#(
  parameter int                 WIDTH       = BF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Flush outranks load; RST is handled in the flop so it wins over both.
  always_comb begin
    data_d = data_q;
    if (CLR) begin
      data_d = RESET_VALUE;
    end else if (EN) begin
      data_d = D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign Q = data_q;

endmodule : bf_stage

// File: rtl/bf_pipe_reg.sv
// Generic pipeline buffer: STAGES chained bf_stage flops, bit-exact transfer.
// Latency: STAGES enabled cycles; backpressure: EN low freezes the whole chain.
module bf_pipe_reg
  import bf_pkg::*;
#(
  parameter int               WIDTH       = BF_DEFAULT_WIDTH,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT
);

  if (WIDTH < 1 || STAGES < 1) begin : g_bad_cfg
    $fatal(1, "bf_pipe_reg: WIDTH and STAGES must both be >= 1");
  end

  // chain[i] feeds stage i; chain[STAGES] is the last stage's output.
  logic [WIDTH-1:0] chain [STAGES+1];

  assign chain[0] = IN;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    bf_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .EN  (EN),
      .D   (chain[g]),
      .Q   (chain[g+1])
    );
  end

  assign OUT = chain[STAGES];

  a_hold_stable : assert property (@(posedge CLK) (!RST && !CLR && !EN) |=> $stable(OUT))
    else $error("bf_pipe_reg: OUT changed while EN was low");

  a_reset_value : assert property (@(posedge CLK) RST |=> (OUT == RESET_VALUE))
    else $error("bf_pipe_reg: OUT not RESET_VALUE after RST");

endmodule : bf_pipe_reg

// File: tb/tb_bf_pipe_reg.sv
// Directed bench for bf_pipe_reg: one-stage (two reset values) and three-stage instances
// driven from shared inputs, each scenario in its own task.
module tb_bf_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [31:0] din;
  logic [31:0] out1;
  logic [31:0] out2;
  logic [31:0] out3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bf_pipe_reg #(.WIDTH(32), .STAGES(1), .RESET_VALUE(32'h0000_0000)) u_dut1 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .IN(din), .OUT(out1));

  bf_pipe_reg #(.WIDTH(32), .STAGES(1), .RESET_VALUE(32'hDEAD_BEEF)) u_dut2 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .IN(din), .OUT(out2));

  bf_pipe_reg #(.WIDTH(32), .STAGES(3), .RESET_VALUE(32'h0000_0000)) u_dut3 (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .IN(din), .OUT(out3));

  // Advance one rising edge and return 1 ns later, clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b1; din = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b1; din = 32'hFFFF_FFFF;
    step();
    din = 32'h1234_5678;
    step();
    if (out1 !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_rv0: got %h expected %h", out1, 32'h0000_0000);
    end
    n_checks++;
    if (out2 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reset_rvdeadbeef: got %h expected %h", out2, 32'hDEAD_BEEF);
    end
    n_checks++;
    if (out3 !== 32'h0000_0000) begin
      n_fail++; $display("FAIL reset_stages3: got %h expected %h", out3, 32'h0000_0000);
    end
    n_checks++;
    rst = 1'b0;
  endtask

  task automatic test_stream1();
    logic [31:0] vec [5];
    vec[0] = 32'h0000_0001; vec[1] = 32'h0000_0002; vec[2] = 32'h0000_000F;
    vec[3] = 32'hF0F0_F0F0; vec[4] = 32'hAAAA_AAAA;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = vec[i];
      step();
      if (out1 !== vec[i]) begin
        n_fail++; $display("FAIL stream1_rv0[%0d]: got %h expected %h", i, out1, vec[i]);
      end
      n_checks++;
      if (out2 !== vec[i]) begin
        n_fail++; $display("FAIL stream1_rvdb[%0d]: got %h expected %h", i, out2, vec[i]);
      end
      n_checks++;
    end
  endtask

  task automatic test_hold();
    en = 1'b1; din = 32'h1234_5678;
    step();
    if (out1 !== 32'h1234_5678) begin
      n_fail++; $display("FAIL hold_load: got %h expected %h", out1, 32'h1234_5678);
    end
    n_checks++;
    en = 1'b0; din = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out1 !== 32'h1234_5678) begin
        n_fail++; $display("FAIL hold_cycle[%0d]: got %h expected %h", i, out1, 32'h1234_5678);
      end
      n_checks++;
    end
    en = 1'b1;
    step();
    if (out1 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL hold_release: got %h expected %h", out1, 32'hFFFF_FFFF);
    end
    n_checks++;
  endtask

  task automatic test_stages3();
    logic [31:0] ins [5];
    logic [31:0] exp [5];
    ins[0] = 32'h1; ins[1] = 32'h2; ins[2] = 32'h3; ins[3] = 32'h0; ins[4] = 32'h0;
    exp[0] = 32'h0; exp[1] = 32'h0; exp[2] = 32'h1; exp[3] = 32'h2; exp[4] = 32'h3;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = ins[i];
      step();
      if (out3 !== exp[i]) begin
        n_fail++; $display("FAIL stages3_edge%0d: got %h expected %h", i + 1, out3, exp[i]);
      end
      n_checks++;
    end
  endtask

  // mode 0: CLR flush, 1: RST, 2: RST with CLR low and EN high
  task automatic test_flush_midstream(input int mode);
    do_reset();
    en = 1'b1;
    din = 32'hA; step();
    din = 32'hB; step();
    din = 32'hC;
    if (mode == 0) clr = 1'b1;
    else           rst = 1'b1;
    step();
    clr = 1'b0; rst = 1'b0; din = 32'h0;
    if (out2 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL flush%0d_rv: got %h expected %h", mode, out2, 32'hDEAD_BEEF);
    end
    n_checks++;
    for (int i = 0; i < 3; i++) begin
      if (out3 !== 32'h0) begin
        n_fail++; $display("FAIL flush%0d_drain[%0d]: got %h expected %h", mode, i, out3, 32'h0);
      end
      n_checks++;
      if (i == 0) din = 32'h77;
      step();
      din = 32'h0;
    end
    if (out3 !== 32'h77) begin
      n_fail++; $display("FAIL flush%0d_resume: got %h expected %h", mode, out3, 32'h77);
    end
    n_checks++;
  endtask

  task automatic test_glitch();
    en = 1'b1;
    din = 32'h5555_AAAA;
    #3;
    din = 32'h0F0F_0F0F;
    step();
    if (out1 !== 32'h0F0F_0F0F) begin
      n_fail++; $display("FAIL glitch_capture: got %h expected %h", out1, 32'h0F0F_0F0F);
    end
    n_checks++;
    din = 32'h5555_AAAA;
    #2;
    if (out1 !== 32'h0F0F_0F0F) begin
      n_fail++; $display("FAIL glitch_between_edges: got %h expected %h", out1, 32'h0F0F_0F0F);
    end
    n_checks++;
    din = 32'h0F0F_0F0F;
    step();
    if (out1 !== 32'h0F0F_0F0F) begin
      n_fail++; $display("FAIL glitch_recapture: got %h expected %h", out1, 32'h0F0F_0F0F);
    end
    n_checks++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; din = 32'h0;
    test_reset();
    test_stream1();
    test_hold();
    test_stages3();
    test_flush_midstream(0);
    test_flush_midstream(1);
    test_flush_midstream(2);
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bf_pipe_reg
